// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay timer: each channel counts ticks after a start
// strobe and pulses done once (one-shot) or every max+1 ticks (periodic).
module multi_delay_timer #(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic [NUM_CH-1:0]               start,
  input  logic [NUM_CH-1:0]               abort,
  input  logic [NUM_CH-1:0]               periodic,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0] max,
  output logic [NUM_CH-1:0]               busy,
  output logic [NUM_CH-1:0]               done,
  output logic                            any_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = '0;

  state_t                   state   [NUM_CH];
  logic [COUNTER_WIDTH-1:0] counter [NUM_CH];
  logic [COUNTER_WIDTH-1:0] max_q   [NUM_CH];
  logic [NUM_CH-1:0]        mode_q;

  // Per-channel FSM; priority is reset, then abort, then start, then counting.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst) begin
        state[i]   <= IDLE;
        counter[i] <= CNT_ZERO;
        max_q[i]   <= CNT_ZERO;
        mode_q[i]  <= 1'b0;
        done[i]    <= 1'b0;
      end else if (abort[i]) begin
        state[i]   <= IDLE;
        counter[i] <= CNT_ZERO;
        done[i]    <= 1'b0;
      end else if (start[i]) begin
        state[i]   <= RUNNING;
        counter[i] <= CNT_ZERO;
        max_q[i]   <= max[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        mode_q[i]  <= periodic[i];
        done[i]    <= 1'b0;
      end else begin
        case (state[i])
          IDLE: begin
            done[i] <= 1'b0;
          end
          RUNNING: begin
            if (tick) begin
              if (counter[i] == max_q[i]) begin
                done[i] <= 1'b1;
                if (mode_q[i]) begin
                  counter[i] <= CNT_ZERO;
                end else begin
                  state[i] <= DONE;
                end
              end else begin
                counter[i] <= counter[i] + CNT_ONE;
                done[i]    <= 1'b0;
              end
            end else begin
              done[i] <= 1'b0;
            end
          end
          DONE: begin
            state[i] <= IDLE;
            done[i]  <= 1'b0;
          end
          default: begin
            state[i] <= IDLE;
            done[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state[i] == RUNNING);
    end
  end

  assign any_done = |done;

endmodule
